// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment display driver.
// Captures a value in hex or decimal form (decimal goes through a sequential
// double-dabble converter), holds it in a display register and scans the
// digits with a dead time at the start of every digit slot to avoid ghosting.
// All outputs are registered and derived from the next-state of the scan
// counter and display register, so seg/dp_out/digit_en always move together.

module seg7_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1_000,
    parameter int DEAD_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  KEY4,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            seg,
    output logic                  dp_out
);

    localparam int VW     = 4 * DIGITS;
    localparam int P      = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W  = (P > 1) ? $clog2(P) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W  = $clog2(VW);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    // 10^n as a 64-bit constant; used for the decimal overflow threshold.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

    // Active-low {a,b,c,d,e,f,g} glyph for one nibble.
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan state
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Conversion state
    logic              busy_q, busy_d;
    logic [BIT_W-1:0]  bitc_q, bitc_d;
    logic [VW-1:0]     sh_q, sh_d;
    logic [VW-1:0]     bcd_q, bcd_d;
    logic [VW-1:0]     bcd_adj;
    logic [VW-1:0]     bcd_step;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              pend_blz_q, pend_blz_d;
    logic              pend_ovf_q, pend_ovf_d;

    // Display register
    logic [VW-1:0]     disp_q, disp_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic              disp_blz_q, disp_blz_d;
    logic              disp_ovf_q, disp_ovf_d;

    // Output registers
    logic [DIGITS-1:0] en_q, en_d;
    logic [6:0]        seg_q, seg_d;
    logic              dpo_q, dpo_d;

    logic                accept;
    logic [DIGITS-1:0]   blank_v;
    logic                allz;
    logic [7*DIGITS-1:0] glyph_flat;
    logic                win_d;
    logic [6:0]          seg_sel;
    logic                dp_sel;

    // A load is only honoured while no conversion is running.
    assign accept = load && !busy_q;

    // Scan counter and digit index advance; index steps on counter wrap.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(P - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Double-dabble add-3 correction, one BCD digit per generate slice.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end

    assign bcd_step = {bcd_adj[VW-2:0], sh_q[VW-1]};

    // Load capture, conversion sequencing and atomic display update.
    always_comb begin
        busy_d     = busy_q;
        bitc_d     = bitc_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        pend_dp_d  = pend_dp_q;
        pend_blz_d = pend_blz_q;
        pend_ovf_d = pend_ovf_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        disp_blz_d = disp_blz_q;
        disp_ovf_d = disp_ovf_q;
        if (accept) begin
            if (hex_mode) begin
                disp_d     = value_in;
                disp_dp_d  = dp_in;
                disp_blz_d = blank_lz;
                disp_ovf_d = 1'b0;
            end else begin
                busy_d     = 1'b1;
                bitc_d     = '0;
                sh_d       = value_in;
                bcd_d      = '0;
                pend_dp_d  = dp_in;
                pend_blz_d = blank_lz;
                pend_ovf_d = (64'(value_in) >= DEC_LIMIT);
            end
        end else if (busy_q) begin
            sh_d   = sh_q << 1;
            bcd_d  = bcd_step;
            bitc_d = bitc_q + 1'b1;
            // Last bit: the shifted result is final, publish everything at once.
            if (bitc_q == BIT_W'(VW - 1)) begin
                busy_d     = 1'b0;
                disp_d     = bcd_step;
                disp_dp_d  = pend_dp_q;
                disp_blz_d = pend_blz_q;
                disp_ovf_d = pend_ovf_q;
            end
        end
    end

    // Leading-zero mask: walk from the top digit down while all nibbles are zero.
    always_comb begin
        blank_v = '0;
        allz    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allz = allz && (disp_d[4*i +: 4] == 4'd0);
            if (i != 0) begin
                blank_v[i] = disp_blz_d && allz;
            end
        end
    end

    // Per-digit glyph for the upcoming display contents.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_glyph
        assign glyph_flat[7*gi +: 7] = disp_ovf_d   ? SEG_DASH :
                                       blank_v[gi]  ? SEG_OFF  :
                                       seg_lut(disp_d[4*gi +: 4]);
    end

    // Select the enabled digit and build the next output values.
    always_comb begin
        win_d   = (int'(cnt_d) >= DEAD_CYC);
        seg_sel = SEG_OFF;
        dp_sel  = 1'b1;
        en_d    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                seg_sel = glyph_flat[7*i +: 7];
                dp_sel  = ~disp_dp_d[i];
                en_d[i] = ~win_d;
            end
        end
        seg_d = win_d ? seg_sel : SEG_OFF;
        dpo_d = win_d ? dp_sel  : 1'b1;
    end

    // Scan and conversion registers; reset wins over any load.
    always_ff @(posedge CLK) begin
        if (KEY4) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            bitc_q     <= '0;
            sh_q       <= '0;
            bcd_q      <= '0;
            pend_dp_q  <= '0;
            pend_blz_q <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            bitc_q     <= bitc_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            pend_dp_q  <= pend_dp_d;
            pend_blz_q <= pend_blz_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

    // Display register; reset shows plain zeros with no decimal points.
    always_ff @(posedge CLK) begin
        if (KEY4) begin
            disp_q     <= '0;
            disp_dp_q  <= '0;
            disp_blz_q <= 1'b0;
            disp_ovf_q <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            disp_blz_q <= disp_blz_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    // Registered digit enables, segments and decimal point.
    always_ff @(posedge CLK) begin
        if (KEY4) begin
            en_q  <= '1;
            seg_q <= SEG_OFF;
            dpo_q <= 1'b1;
        end else begin
            en_q  <= en_d;
            seg_q <= seg_d;
            dpo_q <= dpo_d;
        end
    end

    assign busy     = busy_q;
    assign digit_en = en_q;
    assign seg      = seg_q;
    assign dp_out   = dpo_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with DIGITS=4, P=10, DEAD_CYC=2.
module tb_seg7_scan_controller;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G9 = 7'b0000100;
    localparam logic [6:0] GA = 7'b0001000, GB = 7'b1100000, GC = 7'b0110001;
    localparam logic [6:0] GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;
    localparam logic [6:0] BL = 7'b1111111, DASH = 7'b1111110;

    typedef struct {
        logic        hex;
        logic [15:0] val;
        logic [3:0]  dp;
        logic        blz;
        logic        glitch;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    logic        CLK = 1'b0;
    logic        KEY4;
    logic [15:0] value_in;
    logic        load;
    logic        hex_mode;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        busy;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp_out;

    int checks   = 0;
    int failures = 0;

    vec_t        vecs [9];
    logic [27:0] prev_segs;
    logic [3:0]  prev_dpl;

    seg7_scan_controller #(
        .DIGITS(4), .CLK_HZ(1000), .DIGIT_HZ(100), .DEAD_CYC(2)
    ) dut (
        .CLK(CLK), .KEY4(KEY4), .value_in(value_in), .load(load),
        .hex_mode(hex_mode), .dp_in(dp_in), .blank_lz(blank_lz),
        .busy(busy), .digit_en(digit_en), .seg(seg), .dp_out(dp_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Watch 40 cycles (one full rotation) from a negedge; check glyphs and scan shape.
    task automatic observe(input string tag, input logic [27:0] segs, input logic [3:0] dpl);
        int         low [4];
        logic [6:0] got_seg [4];
        logic       got_dp [4];
        logic       bad [4];
        int         ones = 0;
        int         multi = 0;
        for (int k = 0; k < 4; k++) begin
            low[k] = 0; got_seg[k] = 'x; got_dp[k] = 'x; bad[k] = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            if (digit_en === 4'hF) begin
                ones++;
                if (seg !== BL || dp_out !== 1'b1) multi++;
            end else if ($countones(~digit_en) != 1) begin
                multi++;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (digit_en[k] === 1'b0) begin
                        low[k]++;
                        if (!bad[k]) begin
                            got_seg[k] = seg;
                            got_dp[k]  = dp_out;
                            if (seg !== segs[7*k +: 7] || dp_out !== dpl[k]) bad[k] = 1'b1;
                        end
                    end
                end
            end
            @(negedge CLK);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_seg%0d", tag, k), 32'(got_seg[k]), 32'(segs[7*k +: 7]));
            check($sformatf("%s_dp%0d", tag, k), 32'(got_dp[k]), 32'(dpl[k]));
            check($sformatf("%s_slot%0d", tag, k), 32'(low[k]), 32'd8);
        end
        check({tag, "_dead"}, 32'(ones), 32'd8);
        check({tag, "_overlap"}, 32'(multi), 32'd0);
        $display("txn %s done", tag);
    endtask

    // Apply one load and follow the busy phase; old glyphs must hold meanwhile.
    task automatic run_vec(input string tag, input vec_t v);
        int cnt  = 0;
        int hold = 0;
        value_in = v.val; hex_mode = v.hex; dp_in = v.dp; blank_lz = v.blz; load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        while (busy === 1'b1 && cnt < 60) begin
            cnt++;
            for (int k = 0; k < 4; k++) begin
                if (digit_en === ~(4'b0001 << k)) begin
                    if (seg !== prev_segs[7*k +: 7] || dp_out !== prev_dpl[k]) hold++;
                end
            end
            if (v.glitch && cnt == 3) begin
                value_in = 16'h1111; hex_mode = 1'b1; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge CLK);
        end
        load = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cnt), v.hex ? 32'd0 : 32'd16);
        check({tag, "_hold"}, 32'(hold), 32'd0);
        observe(tag, v.segs, ~v.dp);
        prev_segs = v.segs;
        prev_dpl  = ~v.dp;
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'd1234,  4'b0000, 1'b0, 1'b0, {G1, G2, G3, G4}};
        vecs[1] = '{1'b1, 16'hBEEF,  4'b0000, 1'b0, 1'b0, {GB, GE, GE, GF}};
        vecs[2] = '{1'b0, 16'd7,     4'b0100, 1'b1, 1'b0, {BL, BL, BL, G7}};
        vecs[3] = '{1'b0, 16'd10000, 4'b1010, 1'b1, 1'b0, {DASH, DASH, DASH, DASH}};
        vecs[4] = '{1'b0, 16'd9999,  4'b0000, 1'b0, 1'b1, {G9, G9, G9, G9}};
        vecs[5] = '{1'b1, 16'h00A0,  4'b0001, 1'b1, 1'b0, {BL, BL, GA, G0}};
        vecs[6] = '{1'b0, 16'd0,     4'b1000, 1'b1, 1'b0, {BL, BL, BL, G0}};
        vecs[7] = '{1'b1, 16'h5C6D,  4'b0000, 1'b1, 1'b0, {G5, GC, G6, GD}};
        vecs[8] = '{1'b0, 16'd305,   4'b0010, 1'b1, 1'b0, {BL, G3, G0, G5}};

        // Reset with a load held high; the load must be ignored.
        KEY4 = 1'b1; load = 1'b1; hex_mode = 1'b1; value_in = 16'hFFFF;
        dp_in = 4'hF; blank_lz = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_en", 32'(digit_en), 32'hF);
        check("rst_seg", 32'(seg), 32'(BL));
        check("rst_dp", 32'(dp_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        KEY4 = 1'b0; load = 1'b0;
        @(negedge CLK);
        check("rst_dead1_en", 32'(digit_en), 32'hF);
        @(negedge CLK);
        check("first_win_en", 32'(digit_en), 32'hE);
        check("first_win_seg", 32'(seg), 32'(G0));
        check("first_win_dp", 32'(dp_out), 32'd1);
        @(negedge CLK);
        prev_segs = {G0, G0, G0, G0};
        prev_dpl  = 4'hF;
        observe("after_reset", prev_segs, prev_dpl);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a conversion aborts it and leaves zeros.
        begin
            int cnt = 0;
            value_in = 16'd4321; hex_mode = 1'b0; dp_in = 4'b0110; blank_lz = 1'b1; load = 1'b1;
            @(negedge CLK);
            load = 1'b0;
            while (busy === 1'b1 && cnt < 5) begin
                cnt++;
                if (cnt < 5) @(negedge CLK);
            end
            check("abort_reached", 32'(cnt), 32'd5);
            KEY4 = 1'b1;
            @(negedge CLK);
            KEY4 = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_en", 32'(digit_en), 32'hF);
            observe("abort_a", {G0, G0, G0, G0}, 4'hF);
            repeat (20) @(negedge CLK);
            observe("abort_b", {G0, G0, G0, G0}, 4'hF);
            check("abort_busy_late", 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
